caxi4interconnect_slot_tracker: RTL and testbench



---
 rtl/caxi4interconnect_slot_pkg.sv | 16 +
 rtl/caxi4interconnect_slot_tracker_if.sv | 33 +++
 rtl/caxi4interconnect_onehot_to_bin.sv | 22 ++
 rtl/caxi4interconnect_slot_tracker.sv | 97 +++++++++
 tb/tb_caxi4interconnect_slot_tracker.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/caxi4interconnect_slot_pkg.sv
// Shared constants and helpers for the AXI4 interconnect slot tracker.
// Optional error detection is enabled by defining CAXI4INTERCONNECT_SLOT_TRACK_ERR_EN.
package caxi4interconnect_slot_pkg;

  localparam int SLOT_WIDTH_MIN = 2;
  localparam int SLOT_WIDTH_MAX = 32;

  // Ceiling log2, used for slot-index and outstanding-count widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/caxi4interconnect_slot_tracker_if.sv
// Allocation/release/status bundle between the crossbar control and the slot tracker.
interface caxi4interconnect_slot_tracker_if
  import caxi4interconnect_slot_pkg::*;
#(
  parameter int WIDTH = 4
);
  localparam int IDX_W = clog2(WIDTH);
  localparam int CNT_W = clog2(WIDTH + 1);

  logic             allocValid;
  logic             allocReady;
  logic [WIDTH-1:0] allocOneHot;
  logic [IDX_W-1:0] allocIdx;
  logic             relValid;
  logic [IDX_W-1:0] relIdx;
  logic             flush;
  logic [WIDTH-1:0] busyMask;
  logic [CNT_W-1:0] outstanding;
  logic             full;
  logic             empty;
  logic             relErr;

  modport slave (
    input  allocValid, relValid, relIdx, flush,
    output allocReady, allocOneHot, allocIdx, busyMask, outstanding, full, empty, relErr
  );

  modport master (
    output allocValid, relValid, relIdx, flush,
    input  allocReady, allocOneHot, allocIdx, busyMask, outstanding, full, empty, relErr
  );

endinterface

// File: rtl/caxi4interconnect_onehot_to_bin.sv
// One-hot to binary encoder built as an OR-tree; an all-zero input encodes to 0.
module caxi4interconnect_onehot_to_bin
  import caxi4interconnect_slot_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDX_W = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] oneHot,
  output logic [IDX_W-1:0] idx
);

  // Index bit b is the OR of every one-hot position whose number has bit b set.
  always_comb begin
    idx = '0;
    for (int i = 1; i < WIDTH; i++) begin
      for (int b = 0; b < IDX_W; b++) begin
        if (((i >> b) & 1) == 1) idx[b] = idx[b] | oneHot[i];
      end
    end
  end

endmodule

// File: rtl/caxi4interconnect_slot_tracker.sv
// Slot ownership tracker: grants the lowest free slot, frees slots on release.
// Sticky release-error detection is built only with CAXI4INTERCONNECT_SLOT_TRACK_ERR_EN.
module caxi4interconnect_slot_tracker
  import caxi4interconnect_slot_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic                              sysClk,
  input logic                              sysReset,
  caxi4interconnect_slot_tracker_if.slave  bus
);
  localparam int IDX_W = clog2(WIDTH);
  localparam int CNT_W = clog2(WIDTH + 1);

  if (WIDTH < SLOT_WIDTH_MIN || WIDTH > SLOT_WIDTH_MAX) begin : gBadWidth
    $error("caxi4interconnect_slot_tracker: WIDTH out of range");
  end

  logic [WIDTH-1:0] busyMask;
  logic [WIDTH-1:0] freeMask;
  logic [WIDTH-1:0] allocOneHot;
  logic [WIDTH-1:0] relDecode;
  logic [WIDTH-1:0] nextMask;
  logic [IDX_W-1:0] allocIdx;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] nextCount;
  logic             full;
  logic             empty;
  logic             relErr;
  logic             allocFire;
  logic             relFire;

  // Lowest-set-bit isolate of the free mask; zero when every slot is held.
  assign freeMask    = ~busyMask;
  assign allocOneHot = freeMask & (~freeMask + WIDTH'(1));
  assign allocFire   = bus.allocValid && !full;

  // Out-of-range indices match no decode bit, so they can never fire.
  always_comb begin
    relDecode = '0;
    for (int i = 0; i < WIDTH; i++) relDecode[i] = (bus.relIdx == IDX_W'(i));
  end

  assign relFire = bus.relValid && |(relDecode & busyMask);

  // Allocated and released slots are disjoint, so both apply without conflict.
  always_comb begin
    nextMask = busyMask;
    if (relFire) nextMask = nextMask & ~relDecode;
    if (allocFire) nextMask = nextMask | allocOneHot;
    nextCount = outstanding;
    case ({allocFire, relFire})
      2'b10:   nextCount = outstanding + CNT_W'(1);
      2'b01:   nextCount = outstanding - CNT_W'(1);
      default: nextCount = outstanding;
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (sysReset || bus.flush) begin
      busyMask    <= '0;
      outstanding <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
    end else begin
      busyMask    <= nextMask;
      outstanding <= nextCount;
      full        <= &nextMask;
      empty       <= ~|nextMask;
    end
  end

`ifdef CAXI4INTERCONNECT_SLOT_TRACK_ERR_EN
  // Any release that did not hit a held slot latches the error until reset or flush.
  always_ff @(posedge sysClk) begin
    if (sysReset || bus.flush) relErr <= 1'b0;
    else if (bus.relValid && !relFire) relErr <= 1'b1;
  end
`else
  assign relErr = 1'b0;
`endif

  caxi4interconnect_onehot_to_bin #(.WIDTH(WIDTH)) uIdxEnc (
    .oneHot (allocOneHot),
    .idx    (allocIdx)
  );

  assign bus.allocReady  = ~full;
  assign bus.allocOneHot = allocOneHot;
  assign bus.allocIdx    = allocIdx;
  assign bus.busyMask    = busyMask;
  assign bus.outstanding = outstanding;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.relErr      = relErr;

endmodule

// File: tb/tb_caxi4interconnect_slot_tracker.sv
// Scoreboard bench for caxi4interconnect_slot_tracker at WIDTH=4.
// Honours CAXI4INTERCONNECT_SLOT_TRACK_ERR_EN when predicting relErr.
module tb_caxi4interconnect_slot_tracker;

`ifdef CAXI4INTERCONNECT_SLOT_TRACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] mask;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       err;
  } state_t;

  logic sysClk = 1'b0;
  logic sysReset;
  int   checks = 0;
  int   failures = 0;

  state_t     expQ[$];
  logic [3:0] mdlMask = 4'b0000;
  int         mdlCount = 0;
  logic       mdlErr = 1'b0;

  caxi4interconnect_slot_tracker_if #(.WIDTH(4)) bus ();

  caxi4interconnect_slot_tracker #(.WIDTH(4)) dut (
    .sysClk   (sysClk),
    .sysReset (sysReset),
    .bus      (bus)
  );

  always #5 sysClk = ~sysClk;

  function automatic logic [3:0] mdlOneHot(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (!m[i]) return 4'b0001 << i;
    return 4'b0000;
  endfunction

  function automatic logic [1:0] mdlIdx(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (!m[i]) return 2'(i);
    return 2'd0;
  endfunction

  // Expected {allocReady, allocOneHot, allocIdx} from the model mask.
  function automatic logic [6:0] expGrant();
    return {mdlMask != 4'hF, mdlOneHot(mdlMask), mdlIdx(mdlMask)};
  endfunction

  function automatic state_t expState();
    return {mdlMask, 3'(mdlCount), &mdlMask, ~|mdlMask, mdlErr};
  endfunction

  function automatic state_t snapState();
    return {bus.busyMask, bus.outstanding, bus.full, bus.empty, bus.relErr};
  endfunction

  // Drives one cycle of stimulus, advances the model and queues the expected state.
  task automatic step(input int aV, input int rV, input int rI, input int fl, input int rs);
    logic [3:0] g;
    logic       aFire;
    logic       rFire;
    logic [1:0] ri;
    @(negedge sysClk);
    ri = 2'(rI);
    sysReset       = (rs != 0);
    bus.allocValid = (aV != 0);
    bus.relValid   = (rV != 0);
    bus.relIdx     = ri;
    bus.flush      = (fl != 0);
    g     = mdlOneHot(mdlMask);
    aFire = (aV != 0) && (mdlMask != 4'hF);
    rFire = (rV != 0) && mdlMask[ri];
    if (rs != 0 || fl != 0) begin
      mdlMask  = 4'b0000;
      mdlCount = 0;
      mdlErr   = 1'b0;
    end else begin
      if (rFire) begin
        mdlMask[ri] = 1'b0;
        mdlCount--;
      end
      if (aFire) begin
        mdlMask = mdlMask | g;
        mdlCount++;
      end
      if (ERR_EN && rV != 0 && !rFire) mdlErr = 1'b1;
    end
    expQ.push_back(expState());
    @(posedge sysClk);
    #1;
    sysReset       = 1'b0;
    bus.allocValid = 1'b0;
    bus.relValid   = 1'b0;
    bus.relIdx     = 2'd0;
    bus.flush      = 1'b0;
  endtask

  task automatic test_reset();
    state_t e;
    step(0, 0, 0, 0, 1);
    e = expQ.pop_front();
    checks++;
    if (snapState() !== e) begin
      failures++;
      $display("[TB] FAIL reset_state got=%h exp=%h", snapState(), e);
    end
    checks++;
    if ({bus.allocReady, bus.allocOneHot, bus.allocIdx} !== 7'b1_0001_00) begin
      failures++;
      $display("[TB] FAIL reset_grant got=%b exp=%b", {bus.allocReady, bus.allocOneHot, bus.allocIdx}, 7'b1_0001_00);
    end
  endtask

  task automatic test_fill();
    state_t e;
    step(0, 0, 0, 0, 1);
    void'(expQ.pop_front());
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.allocIdx !== 2'(i)) begin
        failures++;
        $display("[TB] FAIL fill_idx got=%0d exp=%0d", bus.allocIdx, i);
      end
      step(1, 0, 0, 0, 0);
      e = expQ.pop_front();
      checks++;
      if (snapState() !== e) begin
        failures++;
        $display("[TB] FAIL fill_state got=%h exp=%h", snapState(), e);
      end
    end
    checks++;
    if ({bus.allocReady, bus.allocOneHot, bus.full, bus.outstanding} !== {1'b0, 4'b0000, 1'b1, 3'd4}) begin
      failures++;
      $display("[TB] FAIL fill_full got=%b exp=%b", {bus.allocReady, bus.allocOneHot, bus.full, bus.outstanding}, {1'b0, 4'b0000, 1'b1, 3'd4});
    end
  endtask

  // Runs from the full mask left by test_fill.
  task automatic test_release_regrant();
    state_t e;
    step(0, 1, 2, 0, 0);
    e = expQ.pop_front();
    checks++;
    if (snapState() !== e || bus.busyMask !== 4'b1011 || bus.allocIdx !== 2'd2) begin
      failures++;
      $display("[TB] FAIL release_regrant got=%h idx=%0d exp=%h idx=2", snapState(), bus.allocIdx, e);
    end
    step(1, 0, 0, 0, 0);
    e = expQ.pop_front();
    checks++;
    if (snapState() !== e || bus.busyMask !== 4'b1111) begin
      failures++;
      $display("[TB] FAIL regrant_alloc got=%h exp=%h", snapState(), e);
    end
  endtask

  task automatic test_simultaneous();
    state_t e;
    step(0, 0, 0, 0, 1);
    void'(expQ.pop_front());
    step(1, 0, 0, 0, 0);
    void'(expQ.pop_front());
    step(1, 0, 0, 0, 0);
    void'(expQ.pop_front());
    checks++;
    if (bus.allocIdx !== 2'd2) begin
      failures++;
      $display("[TB] FAIL simul_grant got=%0d exp=2", bus.allocIdx);
    end
    step(1, 1, 0, 0, 0);
    e = expQ.pop_front();
    checks++;
    if (snapState() !== e || bus.busyMask !== 4'b0110 || bus.outstanding !== 3'd2) begin
      failures++;
      $display("[TB] FAIL simul_state got=%h exp=%h", snapState(), e);
    end
  endtask

  task automatic test_bad_release();
    state_t e;
    step(0, 0, 0, 0, 1);
    void'(expQ.pop_front());
    step(1, 0, 0, 0, 0);
    void'(expQ.pop_front());
    step(0, 1, 3, 0, 0);
    e = expQ.pop_front();
    checks++;
    if (snapState() !== e || bus.busyMask !== 4'b0001 || bus.relErr !== ERR_EN) begin
      failures++;
      $display("[TB] FAIL bad_release got=%h exp=%h", snapState(), e);
    end
    step(0, 0, 0, 0, 0);
    e = expQ.pop_front();
    checks++;
    if (snapState() !== e || bus.relErr !== ERR_EN) begin
      failures++;
      $display("[TB] FAIL err_sticky got=%h exp=%h", snapState(), e);
    end
  endtask

  task automatic test_flush();
    state_t e;
    step(0, 0, 0, 0, 1);
    void'(expQ.pop_front());
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0);
      void'(expQ.pop_front());
    end
    step(0, 1, 0, 0, 0);
    void'(expQ.pop_front());
    step(0, 1, 2, 0, 0);
    e = expQ.pop_front();
    checks++;
    if (snapState() !== e || bus.busyMask !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL flush_setup got=%h exp=%h", snapState(), e);
    end
    step(0, 1, 0, 0, 0);
    void'(expQ.pop_front());
    checks++;
    if (bus.allocReady !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_ready got=%b exp=1", bus.allocReady);
    end
    step(1, 0, 0, 1, 0);
    e = expQ.pop_front();
    checks++;
    if (snapState() !== e || snapState() !== {4'b0000, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL flush_state got=%h exp=%h", snapState(), e);
    end
  endtask

  task automatic test_reset_mid();
    state_t e;
    step(0, 0, 0, 0, 1);
    void'(expQ.pop_front());
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      void'(expQ.pop_front());
    end
    step(1, 0, 0, 0, 1);
    e = expQ.pop_front();
    checks++;
    if (snapState() !== e || {bus.allocReady, bus.allocOneHot, bus.allocIdx} !== 7'b1_0001_00) begin
      failures++;
      $display("[TB] FAIL reset_mid got=%h exp=%h", snapState(), e);
    end
    step(1, 0, 0, 0, 0);
    e = expQ.pop_front();
    checks++;
    if (snapState() !== e || bus.busyMask !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL reset_mid_alloc got=%h exp=%h", snapState(), e);
    end
  endtask

  task automatic test_random();
    state_t e;
    step(0, 0, 0, 0, 1);
    void'(expQ.pop_front());
    for (int n = 0; n < 80; n++) begin
      checks++;
      if ({bus.allocReady, bus.allocOneHot, bus.allocIdx} !== expGrant()) begin
        failures++;
        $display("[TB] FAIL rand_grant got=%b exp=%b", {bus.allocReady, bus.allocOneHot, bus.allocIdx}, expGrant());
      end
      step(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 15) == 0), 0);
      e = expQ.pop_front();
      checks++;
      if (snapState() !== e) begin
        failures++;
        $display("[TB] FAIL rand_state got=%h exp=%h", snapState(), e);
      end
    end
  endtask

  initial begin
    sysReset       = 1'b0;
    bus.allocValid = 1'b0;
    bus.relValid   = 1'b0;
    bus.relIdx     = 2'd0;
    bus.flush      = 1'b0;
    test_reset();
    test_fill();
    test_release_regrant();
    test_simultaneous();
    test_bad_release();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
